// File: rtl/mem_stage_access_unit.sv
// ============================================================================
// Module   : mem_stage_access_unit
// Brief    : MEM-stage data-memory access over req/ready, upstream stall and
//            MEM/WB register drive. Optional abort on timeout: MEM_TIMEOUT_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_stage_access_unit #(
    parameter int ADDR_W         = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWrite,
    input  logic              MemtoReg,
    input  logic              MemWrite,
    input  logic              MemRead,
    input  logic [31:0]       ALUresult,
    input  logic [31:0]       writedata,
    input  logic [4:0]        writeReg,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata,
    output logic              RegWriteOut,
    output logic              MemtoRegOut,
    output logic [31:0]       readDataOut,
    output logic [31:0]       aluResultOut,
    output logic [4:0]        writeRegOut,
    output logic              mem_error
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;
    logic              r_regwrite_l;
    logic              r_memtoreg_l;
    logic [31:0]       r_alu_l;
    logic [4:0]        r_wreg_l;
    logic [31:0]       r_rdata;
    logic              r_wb_regwrite;
    logic              r_wb_memtoreg;
    logic [31:0]       r_wb_rdata;
    logic [31:0]       r_wb_alu;
    logic [4:0]        r_wb_wreg;
    logic              r_mem_error;

    logic              w_op;
    logic              w_ready;
    logic              w_abort;

    assign w_op    = MemRead | MemWrite;
    assign w_ready = r_mem_req & mem_ready;

`ifdef MEM_TIMEOUT_EN
    localparam int                   c_CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CNT_W-1:0]   c_TO_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [c_CNT_W-1:0] r_cnt;

    assign w_abort = (r_state == S_BUSY) && !w_ready && (r_cnt == c_TO_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (r_state == S_IDLE && w_op) begin
            r_cnt <= '0;
        end else if (r_state == S_BUSY && !w_ready) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
    assign w_abort          = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        stall       = 1'b0;
        case (r_state)
            S_IDLE: begin
                stall = w_op;
                if (w_op) begin
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                stall = 1'b1;
                if (w_ready || w_abort) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mem_req     <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_regwrite_l  <= 1'b0;
            r_memtoreg_l  <= 1'b0;
            r_alu_l       <= '0;
            r_wreg_l      <= '0;
            r_rdata       <= '0;
            r_wb_regwrite <= 1'b0;
            r_wb_memtoreg <= 1'b0;
            r_wb_rdata    <= '0;
            r_wb_alu      <= '0;
            r_wb_wreg     <= '0;
            r_mem_error   <= 1'b0;
        end else begin
            r_mem_error <= w_abort;
            case (r_state)
                S_IDLE: begin
                    if (w_op) begin
                        r_regwrite_l  <= RegWrite;
                        r_memtoreg_l  <= MemtoReg;
                        r_alu_l       <= ALUresult;
                        r_wreg_l      <= writeReg;
                        r_mem_req     <= 1'b1;
                        r_mem_we      <= MemWrite;
                        r_mem_addr    <= ALUresult[ADDR_W-1:0];
                        r_mem_wdata   <= writedata;
                        r_wb_regwrite <= 1'b0;
                        r_wb_memtoreg <= 1'b0;
                        r_wb_rdata    <= '0;
                        r_wb_alu      <= '0;
                        r_wb_wreg     <= '0;
                    end else begin
                        r_wb_regwrite <= RegWrite;
                        r_wb_memtoreg <= MemtoReg;
                        r_wb_rdata    <= '0;
                        r_wb_alu      <= ALUresult;
                        r_wb_wreg     <= writeReg;
                    end
                end
                S_BUSY: begin
                    r_wb_regwrite <= 1'b0;
                    r_wb_memtoreg <= 1'b0;
                    r_wb_rdata    <= '0;
                    r_wb_alu      <= '0;
                    r_wb_wreg     <= '0;
                    if (w_ready) begin
                        r_mem_req <= 1'b0;
                        r_rdata   <= r_mem_we ? 32'd0 : mem_rdata;
                    end else if (w_abort) begin
                        r_mem_req <= 1'b0;
                        r_rdata   <= '0;
                    end
                end
                S_DONE: begin
                    // An aborted access is squashed: no register write-back.
                    r_wb_regwrite <= r_regwrite_l & ~r_mem_error;
                    r_wb_memtoreg <= r_memtoreg_l;
                    r_wb_rdata    <= r_mem_error ? 32'd0 : r_rdata;
                    r_wb_alu      <= r_alu_l;
                    r_wb_wreg     <= r_wreg_l;
                end
                default: begin
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req      = r_mem_req;
    assign mem_we       = r_mem_we;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_mem_wdata;
    assign RegWriteOut  = r_wb_regwrite;
    assign MemtoRegOut  = r_wb_memtoreg;
    assign readDataOut  = r_wb_rdata;
    assign aluResultOut = r_wb_alu;
    assign writeRegOut  = r_wb_wreg;
    assign mem_error    = r_mem_error;

endmodule

`default_nettype wire
